// File: rtl/show_port.sv
// show_port: responder for the cpu's execute-stage show interface.
// Show events are queued in a small FIFO, then drained onto a paced display
// bus where each value is held for HOLD cycles. Per-channel LED registers
// latch the last value popped for each channel. Dropped events are counted.
module show_port #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ShowE,
    input  logic [7:0] ShowDataE,
    output logic       DispValid,
    output logic [1:0] DispChan,
    output logic [7:0] DispData,
    output logic [7:0] Led1,
    output logic [7:0] Led2,
    output logic [7:0] Led3,
    output logic       Full,
    output logic       Overflow,
    output logic [7:0] DropCnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_r;
    logic [HW-1:0]   hold_r;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [9:0]      mem_r [DEPTH];

    logic            event_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic [9:0]      head_s;

    // Pop/push/drop decisions; pop sees only the registered count, so an
    // entry pushed this edge is not popped until the next one.
    always_comb begin
        event_s = (ShowE != 2'b00);
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = (count_r != {CW{1'b0}});
            ST_HOLD: pop_s = (hold_r == {HW{1'b0}}) && (count_r != {CW{1'b0}});
            default: pop_s = 1'b0;
        endcase
        if (event_s && ((count_r < DEPTH_C) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        drop_s = event_s && !push_s;
        head_s = mem_r[rd_ptr_r];
    end

    assign Full = (count_r == DEPTH_C);

    // FIFO storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {ShowE, ShowDataE};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Overflow <= 1'b0;
            DropCnt  <= 8'd0;
        end else if (drop_s) begin
            Overflow <= 1'b1;
            if (DropCnt != 8'hFF) begin
                DropCnt <= DropCnt + 8'd1;
            end
        end
    end

    // Display pacing FSM: pop loads the bus, LEDs and hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            hold_r    <= {HW{1'b0}};
            DispValid <= 1'b0;
            DispChan  <= 2'd0;
            DispData  <= 8'd0;
            Led1      <= 8'd0;
            Led2      <= 8'd0;
            Led3      <= 8'd0;
        end else if (pop_s) begin
            state_r   <= ST_HOLD;
            hold_r    <= HOLD_LOAD;
            DispValid <= 1'b1;
            DispChan  <= head_s[9:8];
            DispData  <= head_s[7:0];
            case (head_s[9:8])
                2'b01:   Led1 <= head_s[7:0];
                2'b10:   Led2 <= head_s[7:0];
                2'b11:   Led3 <= head_s[7:0];
                default: Led1 <= Led1;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: DispValid <= 1'b0;
                ST_HOLD: begin
                    if (hold_r != {HW{1'b0}}) begin
                        hold_r <= hold_r - HW'(1);
                    end else begin
                        DispValid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    DispValid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_show_port.sv
// Scoreboard bench for show_port: one instance with HOLD=4, one with HOLD=1.
module tb_show_port;

    logic       clk;
    logic       reset;
    logic [1:0] ShowE4, ShowE1;
    logic [7:0] ShowDataE4, ShowDataE1;
    logic       DispValid4, DispValid1;
    logic [1:0] DispChan4, DispChan1;
    logic [7:0] DispData4, DispData1;
    logic [7:0] Led1_4, Led2_4, Led3_4, Led1_1, Led2_1, Led3_1;
    logic       Full4, Full1, Overflow4, Overflow1;
    logic [7:0] DropCnt4, DropCnt1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit sb_off = 1'b0;

    logic [9:0] q4[$];
    logic [9:0] q1[$];

    show_port #(.DEPTH(4), .HOLD(4)) dut4 (
        .clk(clk), .reset(reset), .ShowE(ShowE4), .ShowDataE(ShowDataE4),
        .DispValid(DispValid4), .DispChan(DispChan4), .DispData(DispData4),
        .Led1(Led1_4), .Led2(Led2_4), .Led3(Led3_4),
        .Full(Full4), .Overflow(Overflow4), .DropCnt(DropCnt4)
    );

    show_port #(.DEPTH(4), .HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .ShowE(ShowE1), .ShowDataE(ShowDataE1),
        .DispValid(DispValid1), .DispChan(DispChan1), .DispData(DispData1),
        .Led1(Led1_1), .Led2(Led2_1), .Led3(Led3_1),
        .Full(Full1), .Overflow(Overflow1), .DropCnt(DropCnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one event on the HOLD=4 instance for one edge; queue it if accepted.
    task automatic show4(input logic [1:0] ch, input logic [7:0] v, input bit acc);
        ShowE4 = ch;
        ShowDataE4 = v;
        if (acc) q4.push_back({ch, v});
        @(posedge clk);
        #1;
        ShowE4 = 2'b00;
    endtask

    task automatic show1(input logic [1:0] ch, input logic [7:0] v);
        ShowE1 = ch;
        ShowDataE1 = v;
        q1.push_back({ch, v});
        @(posedge clk);
        #1;
        ShowE1 = 2'b00;
    endtask

    // Monitor for HOLD=4 instance: pops expected value on each new display item
    // and checks each item was held exactly 4 cycles.
    logic       m4_pv = 1'b0;
    logic [9:0] m4_prev = 10'd0;
    int         m4_run = 0;
    always @(negedge clk) begin
        if (reset || sb_off) begin
            m4_pv  = 1'b0;
            m4_run = 0;
        end else begin
            if (DispValid4 && (!m4_pv || ({DispChan4, DispData4} != m4_prev))) begin
                if (m4_pv) chk("hold4_len", 32'(m4_run), 32'd4);
                if (q4.size() == 0) begin
                    chk("disp4_unexpected", 32'({DispChan4, DispData4}), 32'h3FF);
                end else begin
                    chk("disp4_value", 32'({DispChan4, DispData4}), 32'(q4.pop_front()));
                end
                m4_run = 1;
            end else if (DispValid4) begin
                m4_run++;
            end else if (m4_pv) begin
                chk("hold4_len", 32'(m4_run), 32'd4);
                m4_run = 0;
            end
            m4_pv   = DispValid4;
            m4_prev = {DispChan4, DispData4};
        end
    end

    // Monitor for HOLD=1 instance.
    logic       m1_pv = 1'b0;
    logic [9:0] m1_prev = 10'd0;
    int         m1_run = 0;
    always @(negedge clk) begin
        if (reset) begin
            m1_pv  = 1'b0;
            m1_run = 0;
        end else begin
            if (DispValid1 && (!m1_pv || ({DispChan1, DispData1} != m1_prev))) begin
                if (m1_pv) chk("hold1_len", 32'(m1_run), 32'd1);
                if (q1.size() == 0) begin
                    chk("disp1_unexpected", 32'({DispChan1, DispData1}), 32'h3FF);
                end else begin
                    chk("disp1_value", 32'({DispChan1, DispData1}), 32'(q1.pop_front()));
                end
                m1_run = 1;
            end else if (DispValid1) begin
                m1_run++;
            end else if (m1_pv) begin
                chk("hold1_len", 32'(m1_run), 32'd1);
                m1_run = 0;
            end
            m1_pv   = DispValid1;
            m1_prev = {DispChan1, DispData1};
        end
    end

    task automatic chk_all_zero4(input string tag);
        chk({tag, "_valid"},  32'(DispValid4), 32'd0);
        chk({tag, "_chan"},   32'(DispChan4),  32'd0);
        chk({tag, "_data"},   32'(DispData4),  32'd0);
        chk({tag, "_led1"},   32'(Led1_4),     32'd0);
        chk({tag, "_led2"},   32'(Led2_4),     32'd0);
        chk({tag, "_led3"},   32'(Led3_4),     32'd0);
        chk({tag, "_full"},   32'(Full4),      32'd0);
        chk({tag, "_ovf"},    32'(Overflow4),  32'd0);
        chk({tag, "_drops"},  32'(DropCnt4),   32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ShowE4 = 2'b00; ShowDataE4 = 8'd0;
        ShowE1 = 2'b00; ShowDataE1 = 8'd0;
        @(posedge clk);
        #1;
        chk_all_zero4("reset");
        chk("reset_valid1", 32'(DispValid1), 32'd0);
        reset = 1'b0;

        // Idle: nothing happens for 20 cycles.
        repeat (20) @(posedge clk);
        #1;
        chk_all_zero4("idle");

        // Single event on channel 2.
        show4(2'b10, 8'h5A, 1'b1);
        chk("single_not_early", 32'(DispValid4), 32'd0);
        @(posedge clk); #1;
        chk("single_valid", 32'(DispValid4), 32'd1);
        chk("single_chan",  32'(DispChan4),  32'd2);
        chk("single_data",  32'(DispData4),  32'h5A);
        chk("single_led2",  32'(Led2_4),     32'h5A);
        repeat (3) @(posedge clk); #1;
        chk("single_still_valid", 32'(DispValid4), 32'd1);
        @(posedge clk); #1;
        chk("single_done_valid", 32'(DispValid4), 32'd0);
        chk("single_led2_kept",  32'(Led2_4),     32'h5A);
        repeat (3) @(posedge clk); #1;

        // Burst of 7: e5 accepted while Full thanks to a same-edge pop, e6 dropped.
        for (int i = 0; i < 7; i++) begin
            if (i == 5) chk("burst_full_before_e5", 32'(Full4), 32'd1);
            show4(2'b01, 8'(8'h10 + i), (i < 6));
        end
        chk("burst_ovf",   32'(Overflow4), 32'd1);
        chk("burst_drops", 32'(DropCnt4),  32'd1);
        chk("burst_full",  32'(Full4),     32'd1);
        repeat (25) @(posedge clk); #1;
        chk("burst_led1",  32'(Led1_4),     32'h15);
        chk("burst_idle",  32'(DispValid4), 32'd0);
        chk("burst_empty", 32'(Full4),      32'd0);

        // HOLD=1 throughput: one event per cycle, display one edge behind.
        for (int i = 0; i < 10; i++) begin
            show1(2'b11, 8'(8'h30 + i));
            if (i >= 1) chk("tput_data", 32'(DispData1), 32'(8'h30 + i - 1));
        end
        repeat (4) @(posedge clk); #1;
        chk("tput_drops", 32'(DropCnt1),   32'd0);
        chk("tput_ovf",   32'(Overflow1),  32'd0);
        chk("tput_led3",  32'(Led3_1),     32'h39);
        chk("tput_idle",  32'(DispValid1), 32'd0);

        // Saturation: continuous events far outrun the drain rate.
        sb_off = 1'b1;
        for (int i = 0; i < 500; i++) show4(2'b01, 8'(i), 1'b0);
        chk("sat_drops", 32'(DropCnt4),  32'd255);
        chk("sat_ovf",   32'(Overflow4), 32'd1);
        for (int i = 0; i < 10; i++) show4(2'b10, 8'(i), 1'b0);
        chk("sat_drops_hold", 32'(DropCnt4), 32'd255);
        repeat (30) @(posedge clk); #1;
        chk("sat_drained", 32'(DispValid4), 32'd0);
        sb_off = 1'b0;

        // Reset mid-HOLD with 3 entries queued.
        show4(2'b01, 8'hA0, 1'b1);
        show4(2'b10, 8'hA1, 1'b1);
        show4(2'b11, 8'hA2, 1'b1);
        show4(2'b01, 8'hA3, 1'b1);
        chk("pre_reset_valid", 32'(DispValid4), 32'd1);
        chk("pre_reset_ovf",   32'(Overflow4),  32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero4("async_reset");
        q4.delete();
        #4;
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("post_reset_valid", 32'(DispValid4), 32'd0);
        chk("post_reset_full",  32'(Full4),      32'd0);
        show4(2'b10, 8'hC3, 1'b1);
        chk("post_reset_not_early", 32'(DispValid4), 32'd0);
        @(posedge clk); #1;
        chk("post_reset_valid2", 32'(DispValid4), 32'd1);
        chk("post_reset_data",   32'(DispData4),  32'hC3);
        chk("post_reset_led2",   32'(Led2_4),     32'hC3);
        repeat (6) @(posedge clk); #1;

        chk("q4_empty", 32'(q4.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
